// File: rtl/upmix_pkg.sv
// Shared constants and elaboration-time helpers for the up/down mixers.
package upmix_pkg;

    typedef enum logic {
        DF_IDLE,
        DF_HAVE_RE
    } dfr_state_t;

    // Quarter cycle of the LUT is 2^(abits - QUARTER_SHIFT) entries.
    localparam int QUARTER_SHIFT = 2;

    function automatic logic [63:0] phase_inc(longint freq, longint samp_rate, int phase_bits);
        logic [63:0] num;
        num = (64'(freq) << phase_bits) + 64'(samp_rate / 2);
        return num / 64'(samp_rate);
    endfunction

    function automatic int cos_entry(int dw, int abits, int k);
        real amp;
        real v;
        amp = real'((1 << (dw - 1)) - 1);
        v = amp * $cos(2.0 * 3.14159265358979323846 * real'(k) / real'(1 << abits));
        if (v >= 0.0)
            return $rtoi(v + 0.5);
        return -$rtoi(0.5 - v);
    endfunction

    // Round half-up, drop dw-1 fraction bits, clamp to a signed dw-bit range.
    function automatic longint sat_round(longint x, int dw);
        longint y;
        longint hi;
        longint lo;
        y  = (x + (longint'(1) <<< (dw - 2))) >>> (dw - 1);
        hi = (longint'(1) <<< (dw - 1)) - 1;
        lo = -(longint'(1) <<< (dw - 1));
        if (y > hi)
            return hi;
        if (y < lo)
            return lo;
        return y;
    endfunction

endpackage

// File: rtl/cos_lut.sv
// Full-cycle cosine ROM with two synchronous read ports, one cycle read latency.
module cos_lut
    import upmix_pkg::*;
#(
    parameter int DW    = 12,
    parameter int ABITS = 10
) (
    input  logic                    clk,
    input  logic [ABITS-1:0]        addr_a_i,
    input  logic [ABITS-1:0]        addr_b_i,
    output logic signed [DW-1:0]    data_a_o,
    output logic signed [DW-1:0]    data_b_o
);

    logic signed [DW-1:0] rom [2**ABITS];
    logic signed [DW-1:0] rd_a_q;
    logic signed [DW-1:0] rd_b_q;

    for (genvar k = 0; k < 2**ABITS; k++) begin : g_rom
        assign rom[k] = DW'(cos_entry(DW, ABITS, k));
    end

    always_ff @(posedge clk) begin
        rd_a_q <= rom[addr_a_i];
        rd_b_q <= rom[addr_b_i];
    end

    assign data_a_o = rd_a_q;
    assign data_b_o = rd_b_q;

endmodule

// File: rtl/iq_upmixer.sv
// Deframes {re, im} beat pairs and mixes them with an NCO carrier into one real sample.
// Four-stage pipeline (addr, LUT, multiply, scale); no backpressure.
module iq_upmixer
    import upmix_pkg::*;
#(
    parameter int DW         = 12,
    parameter int SAMP_RATE  = 5_000_000,
    parameter int FREQ       = 457_000,
    parameter int LUT_ABITS  = 10,
    parameter int PHASE_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] data_i,
    input  logic                 valid_i,
    output logic signed [DW-1:0] data_o,
    output logic                 valid_o,
    output logic                 frame_err_o
);

    localparam int PW = 2 * DW;
    localparam logic [PHASE_BITS-1:0] PHASE_INC = PHASE_BITS'(phase_inc(FREQ, SAMP_RATE, PHASE_BITS));
    localparam logic [LUT_ABITS-1:0]  QOFF      = LUT_ABITS'(1) << (LUT_ABITS - QUARTER_SHIFT);

    dfr_state_t            state_q;
    logic [PHASE_BITS-1:0] phase_q;
    logic signed [DW-1:0]  re_hold_q, re0_q, im0_q, re1_q, im1_q, data_q;
    logic [LUT_ABITS-1:0]  cos_addr_q, sin_addr_q;
    logic                  v0_q, v1_q, v2_q, valid_q, ferr_q;
    logic signed [PW-1:0]  prod_c_q, prod_s_q;
    logic signed [DW-1:0]  cos_w, sin_w;
    logic                  launch;
    logic [LUT_ABITS-1:0]  addr_d;
    logic signed [PW:0]    diff_d;
    logic signed [DW-1:0]  data_d;

    assign launch = (state_q == DF_HAVE_RE) && valid_i;
    assign addr_d = phase_q[PHASE_BITS-1 -: LUT_ABITS];

    cos_lut #(.DW(DW), .ABITS(LUT_ABITS)) u_lut (
        .clk      (clk),
        .addr_a_i (cos_addr_q),
        .addr_b_i (sin_addr_q),
        .data_a_o (cos_w),
        .data_b_o (sin_w)
    );

    always_comb begin
        diff_d = (PW+1)'(prod_c_q) - (PW+1)'(prod_s_q);
        data_d = DW'(sat_round(longint'(diff_d), DW));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= DF_IDLE;
            phase_q    <= '0;
            re_hold_q  <= '0;
            re0_q      <= '0;
            im0_q      <= '0;
            re1_q      <= '0;
            im1_q      <= '0;
            cos_addr_q <= '0;
            sin_addr_q <= '0;
            prod_c_q   <= '0;
            prod_s_q   <= '0;
            data_q     <= '0;
            v0_q       <= 1'b0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            case (state_q)
                DF_IDLE: begin
                    if (valid_i) begin
                        re_hold_q <= data_i;
                        state_q   <= DF_HAVE_RE;
                    end
                end
                DF_HAVE_RE: begin
                    // A gap after the re beat abandons the pair.
                    ferr_q  <= !valid_i;
                    state_q <= DF_IDLE;
                end
                default: state_q <= DF_IDLE;
            endcase

            v0_q <= launch;
            if (launch) begin
                re0_q      <= re_hold_q;
                im0_q      <= data_i;
                cos_addr_q <= addr_d;
                sin_addr_q <= addr_d - QOFF;
                phase_q    <= phase_q + PHASE_INC;
            end

            v1_q  <= v0_q;
            re1_q <= re0_q;
            im1_q <= im0_q;

            v2_q <= v1_q;
            if (v1_q) begin
                prod_c_q <= PW'(re1_q) * PW'(cos_w);
                prod_s_q <= PW'(im1_q) * PW'(sin_w);
            end

            valid_q <= v2_q;
            if (v2_q)
                data_q <= data_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_iq_upmixer.sv
// Directed bench: default-carrier DUT (a) plus a 625 kHz DUT (b) whose phase hits exact LUT points.
module tb_iq_upmixer;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [11:0] data_i = '0;
    logic               valid_i = 1'b0;
    logic signed [11:0] dat_a, dat_b;
    logic               vld_a, vld_b, ferr_a, ferr_b;

    int nchecks = 0;
    int nerr    = 0;
    int cyc     = 0;

    int cnt_a = 0, cnt_b = 0, ferr_cnt_a = 0, ferr_cnt_b = 0;
    int last_cyc_a = 0, ferr_cyc_a = 0;
    logic signed [11:0] last_a = '0, last_b = '0;
    int                 pcyc_b[$];
    logic signed [11:0] pdat_b[$];

    iq_upmixer u_dut_a (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
        .data_o(dat_a), .valid_o(vld_a), .frame_err_o(ferr_a)
    );

    iq_upmixer #(.FREQ(625_000)) u_dut_b (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
        .data_o(dat_b), .valid_o(vld_b), .frame_err_o(ferr_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vld_a) begin
            cnt_a++;
            last_a = dat_a;
            last_cyc_a = cyc;
        end
        if (vld_b) begin
            cnt_b++;
            last_b = dat_b;
            pcyc_b.push_back(cyc);
            pdat_b.push_back(dat_b);
        end
        if (ferr_a) begin
            ferr_cnt_a++;
            ferr_cyc_a = cyc;
        end
        if (ferr_b) ferr_cnt_b++;
    end

    task automatic check(input string name, input int act, input int exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic beat(input logic v, input int d);
        @(negedge clk);
        valid_i = v;
        data_i  = 12'(d);
    endtask

    int im_cyc = 0;
    int re_cyc = 0;

    task automatic send_pair(input int re, input int im);
        beat(1'b1, re);
        beat(1'b1, im);
        im_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) beat(1'b0, 0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        valid_i = 1'b0;
        data_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        int re;
        int im;
        int npre;
        bit alt;
        int exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int base_a, base_b, fb_a, fb_b, qb, bad;
        int exp_burst[4];

        // {re, im, zero pairs before, use 625 kHz DUT, expected data_o}
        vecs[0] = '{1000,     0, 0, 1'b0,  1000};
        vecs[1] = '{0,     1000, 0, 1'b0,     0};
        vecs[2] = '{-1000,    0, 0, 1'b0, -1000};
        vecs[3] = '{2047,     5, 0, 1'b0,  2046};
        vecs[4] = '{2047, -2048, 1, 1'b1,  2047};
        vecs[5] = '{-2048, 2047, 1, 1'b1, -2048};
        vecs[6] = '{0,     1000, 2, 1'b1, -1000};
        vecs[7] = '{1000,     0, 3, 1'b1,  -707};
        vecs[8] = '{1000,     0, 4, 1'b1, -1000};
        vecs[9] = '{1000,     0, 1, 1'b1,   707};

        repeat (3) @(negedge clk);
        #1;
        check("reset data_o", int'(dat_a), 0);
        check("reset valid_o", int'(vld_a), 0);
        check("reset frame_err_o", int'(ferr_a), 0);

        for (int i = 0; i < 10; i++) begin
            reset_dut();
            base_a = cnt_a;
            base_b = cnt_b;
            for (int p = 0; p < vecs[i].npre; p++) send_pair(0, 0);
            send_pair(vecs[i].re, vecs[i].im);
            idle(8);
            if (vecs[i].alt) begin
                check($sformatf("vec%0d count", i), cnt_b - base_b, vecs[i].npre + 1);
                check($sformatf("vec%0d data", i), int'(last_b), vecs[i].exp);
            end else begin
                check($sformatf("vec%0d count", i), cnt_a - base_a, 1);
                check($sformatf("vec%0d data", i), int'(last_a), vecs[i].exp);
            end
            if (i == 0) check("latency", last_cyc_a - im_cyc, 4);
        end

        // Abandoned pair: error pulse, no output, phase untouched.
        reset_dut();
        base_a = cnt_a;
        base_b = cnt_b;
        fb_a = ferr_cnt_a;
        fb_b = ferr_cnt_b;
        beat(1'b1, 1000);
        re_cyc = cyc;
        idle(4);
        check("ferr pulses", ferr_cnt_a - fb_a, 1);
        check("ferr pulses b", ferr_cnt_b - fb_b, 1);
        check("ferr timing", ferr_cyc_a - re_cyc, 2);
        check("ferr no output", cnt_a - base_a, 0);
        send_pair(1000, 0);
        idle(8);
        check("after ferr count", cnt_b - base_b, 1);
        check("after ferr phase b", int'(last_b), 1000);
        check("after ferr phase a", int'(last_a), 1000);

        // valid_i held for 8 cycles -> 4 pairs.
        reset_dut();
        base_a = cnt_a;
        base_b = cnt_b;
        qb = pcyc_b.size();
        for (int p = 0; p < 4; p++) send_pair(1000, 0);
        idle(8);
        check("burst count a", cnt_a - base_a, 4);
        check("burst count b", cnt_b - base_b, 4);
        exp_burst = '{1000, 707, 0, -707};
        bad = 0;
        for (int p = 0; p < 4 && qb + p < pdat_b.size(); p++) begin
            if (int'(pdat_b[qb + p]) != exp_burst[p]) bad++;
            if (p > 0 && pcyc_b[qb + p] - pcyc_b[qb + p - 1] != 2) bad++;
        end
        check("burst values and spacing", bad, 0);
        send_pair(1000, 0);
        idle(8);
        check("burst phase advance", int'(last_b), -1000);

        // Asynchronous reset in the middle of a stream.
        reset_dut();
        for (int p = 0; p < 3; p++) send_pair(1000, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset data_o", int'(dat_b), 0);
        check("midreset valid_o", int'(vld_b), 0);
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        base_b = cnt_b;
        idle(8);
        check("midreset flushed", cnt_b - base_b, 0);
        send_pair(1000, 0);
        idle(8);
        check("midreset phase restart", int'(last_b), 1000);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/iq_upmixer.md
# iq_upmixer

Transmit-direction counterpart of the receive downconversion mixer. It accepts a complex baseband stream serialized as {re, im} beat pairs on one DW-bit bus and multiplies each pair by a numerically controlled carrier e^{+jωt}. It emits one real passband sample per pair, y = re·cos(θ) − im·sin(θ). It drives the DAC/test-signal path at SAMP_RATE with the same carrier (457 kHz) and LUT depth as the receive chain, so loopback through the downconverter recovers the original baseband.

## Interface
- DW, 12, signed sample width of input beats and output sample
- SAMP_RATE, 5_000_000, output sample rate in Hz (one output per input pair)
- FREQ, 457_000, carrier frequency in Hz
- LUT_ABITS, 10, cosine LUT address bits (2^LUT_ABITS entries, full cycle)
- PHASE_BITS, 32, phase accumulator width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- data_i  in  DW  signed beat: re on first beat of pair, im on second
- valid_i  in  1  beat qualifier
- data_o  out  DW  signed real output sample
- valid_o  out  1  one-cycle pulse per output sample
- frame_err_o  out  1  one-cycle pulse when a pair is abandoned after one beat

## Operation
- PHASE_INC = round(FREQ·2^PHASE_BITS / SAMP_RATE), elaboration-time constant; defaults give 392_560_011.
- Deframer FSM states:
  - IDLE: valid_i=1 → capture re, go HAVE_RE.
  - HAVE_RE: valid_i=1 → capture im, launch pair, go IDLE. valid_i=0 → discard re, pulse frame_err_o, go IDLE.
- valid_i held high for 2N cycles yields N back-to-back pairs; a third consecutive beat starts a new pair as re.
- Launch: LUT address a = phase[PHASE_BITS-1 -: LUT_ABITS], then phase += PHASE_INC (mod 2^PHASE_BITS).
- Phase advances only on a completed pair; abandoned pairs leave phase unchanged.
- LUT entry k = round((2^(DW-1)−1)·cos(2πk/2^LUT_ABITS)), signed DW.
- cos = LUT[a]; sin = LUT[(a − 2^(LUT_ABITS−2)) mod 2^LUT_ABITS].
- Arithmetic: products re·cos and im·sin are 2DW signed; difference is 2DW+1 signed.
- Scaling: add 2^(DW−2), arithmetic shift right DW−1, saturate to [−2^(DW−1), 2^(DW−1)−1].
- Reset values: data_o=0, valid_o=0, frame_err_o=0, phase=0, FSM IDLE, all pipeline valids cleared.
- Reset mid-pair or mid-pipeline discards all in-flight data; no output is produced for it.

## Timing
- Pipeline stages, with the im beat sampled at edge k:
  - S0 (edge k): re/im registered, LUT address registered, phase updated.
  - S1 (edge k+1): synchronous LUT read, cos/sin registered.
  - S2 (edge k+2): products registered.
  - S3 (edge k+3): data_o and valid_o registered.
- Latency: valid_o high for exactly the cycle following edge k+3.
- Throughput: one pair every 2 cycles minimum; no backpressure, no stalls.
- data_o holds its last value while valid_o=0.
- frame_err_o pulses in the cycle after the edge at which HAVE_RE sees valid_i=0.

## Structure
- Package upmix_pkg holds:
  - phase_inc function (FREQ, SAMP_RATE, PHASE_BITS → increment)
  - cosine LUT init function (DW, LUT_ABITS)
  - quarter-cycle offset constant
  - saturate/round helper
- Sub-module cos_lut: dual-read-port synchronous ROM, 1-cycle read latency, initialized from upmix_pkg; shared with the receive-side mixer.

## Test plan
- Reset, then pair re=1000, im=0 (phase 0; cos=2047) → single valid_o pulse 3 cycles after the im beat, data_o=1000.
- Pair re=0, im=1000 at phase 0 → data_o=0 (sin index −256 maps to LUT[768]=0).
- FREQ=625_000 (PHASE_INC=2^29): pairs (0,0) then (2047,−2048) → second pair addr 128, cos=sin=1447, raw result 2893 → data_o saturates to 2047; with (−2048,2047), data_o=−2048.
- Single beat with valid_i then low → frame_err_o pulse, no valid_o; next full pair still uses phase 0 (data_o=1000 for re=1000, im=0).
- valid_i held high for 8 cycles → exactly 4 valid_o pulses, spaced 2 cycles apart, phase advanced 4·PHASE_INC.
- Continuous default-FREQ stream with constant (1000,0) fed into the receive mixer → recovered |re+j·im| ≈ 500±2 after filtering; assert rst mid-stream → outputs 0 within one cycle, phase restarts at 0.
